// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: one AXI-style read per instruction, handing a single
// 32-bit word to the decoder with redirect support for jumps and pipeline flushes.
module ysyx_22050019_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,

    output logic        ar_valid_o,
    input  logic        ar_ready_i,
    output logic [63:0] ar_addr_o,

    input  logic        r_valid_i,
    output logic        r_ready_o,
    input  logic [63:0] r_data_i,
    input  logic [1:0]  r_resp_i,

    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [63:0] inst_addr_pc_o,
    output logic        fetch_err_o,

    input  logic        jump_i,
    input  logic [63:0] jump_pc_i,
    input  logic        flush_i,
    input  logic [63:0] flush_pc_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state_reg;
    logic [63:0] pc_reg;
    logic        pending_flush_reg;
    logic [63:0] flush_pc_reg;
    logic [31:0] inst_reg;
    logic        fetch_err_reg;
    logic        ar_valid_reg;
    logic        r_ready_reg;
    logic        inst_valid_reg;

    logic [63:0] flush_target;
    logic [63:0] handshake_pc;
    logic [31:0] beat_word;

    function automatic logic is_aligned(input logic [1:0] pc_low);
        return pc_low == 2'b00;
    endfunction

    // A flush arriving this cycle supersedes any target saved earlier.
    always_comb begin
        flush_target = flush_i ? flush_pc_i : flush_pc_reg;
        handshake_pc = jump_i ? jump_pc_i : pc_reg + 64'd4;
        beat_word    = pc_reg[2] ? r_data_i[63:32] : r_data_i[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            pc_reg            <= RESET_PC;
            pending_flush_reg <= 1'b0;
            flush_pc_reg      <= 64'd0;
            inst_reg          <= 32'd0;
            fetch_err_reg     <= 1'b0;
            ar_valid_reg      <= 1'b0;
            r_ready_reg       <= 1'b0;
            inst_valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flush_i) begin
                        pending_flush_reg <= 1'b1;
                        flush_pc_reg      <= flush_pc_i;
                    end
                    ar_valid_reg <= is_aligned(pc_reg[1:0]);
                    state_reg    <= AR;
                end

                AR: begin
                    if (ar_valid_reg) begin
                        // Address stays put; a flush is only remembered until the beat returns.
                        if (flush_i) begin
                            pending_flush_reg <= 1'b1;
                            flush_pc_reg      <= flush_pc_i;
                        end
                        if (ar_ready_i) begin
                            ar_valid_reg <= 1'b0;
                            r_ready_reg  <= 1'b1;
                            state_reg    <= R;
                        end
                    end else if (flush_i || pending_flush_reg) begin
                        // Misaligned PC has nothing on the bus, so redirect at once.
                        pc_reg            <= flush_target;
                        pending_flush_reg <= 1'b0;
                        ar_valid_reg      <= is_aligned(flush_target[1:0]);
                    end else begin
                        inst_reg       <= NOP_INST;
                        fetch_err_reg  <= 1'b1;
                        inst_valid_reg <= 1'b1;
                        state_reg      <= OUT;
                    end
                end

                R: begin
                    if (r_valid_i) begin
                        r_ready_reg <= 1'b0;
                        if (flush_i || pending_flush_reg) begin
                            pc_reg            <= flush_target;
                            pending_flush_reg <= 1'b0;
                            ar_valid_reg      <= is_aligned(flush_target[1:0]);
                            state_reg         <= AR;
                        end else begin
                            inst_reg       <= (r_resp_i != 2'b00) ? NOP_INST : beat_word;
                            fetch_err_reg  <= (r_resp_i != 2'b00);
                            inst_valid_reg <= 1'b1;
                            state_reg      <= OUT;
                        end
                    end else if (flush_i) begin
                        pending_flush_reg <= 1'b1;
                        flush_pc_reg      <= flush_pc_i;
                    end
                end

                OUT: begin
                    if (flush_i) begin
                        pc_reg            <= flush_pc_i;
                        pending_flush_reg <= 1'b0;
                        inst_valid_reg    <= 1'b0;
                        ar_valid_reg      <= is_aligned(flush_pc_i[1:0]);
                        state_reg         <= AR;
                    end else if (inst_ready_i) begin
                        pc_reg         <= handshake_pc;
                        inst_valid_reg <= 1'b0;
                        ar_valid_reg   <= is_aligned(handshake_pc[1:0]);
                        state_reg      <= AR;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ar_valid_o     = ar_valid_reg;
    assign ar_addr_o      = {pc_reg[63:3], 3'b000};
    assign r_ready_o      = r_ready_reg;
    assign inst_valid_o   = inst_valid_reg;
    assign inst_o         = inst_reg;
    assign inst_addr_pc_o = pc_reg;
    assign fetch_err_o    = fetch_err_reg;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Directed bench for the fetch unit: a tiny memory responder feeds beats and a
// scoreboard queue holds the instruction each accepted beat should produce.
module tb_ysyx_22050019_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid_o;
    logic        ar_ready_i = 1'b0;
    logic [63:0] ar_addr_o;
    logic        r_valid_i = 1'b0;
    logic        r_ready_o;
    logic [63:0] r_data_i = 64'd0;
    logic [1:0]  r_resp_i = 2'b00;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_pc_o;
    logic        fetch_err_o;
    logic        jump_i = 1'b0;
    logic [63:0] jump_pc_i = 64'd0;
    logic        flush_i = 1'b0;
    logic [63:0] flush_pc_i = 64'd0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ysyx_22050019_ifu dut (
        .clk           (clk),
        .rst           (rst),
        .ar_valid_o    (ar_valid_o),
        .ar_ready_i    (ar_ready_i),
        .ar_addr_o     (ar_addr_o),
        .r_valid_i     (r_valid_i),
        .r_ready_o     (r_ready_o),
        .r_data_i      (r_data_i),
        .r_resp_i      (r_resp_i),
        .inst_valid_o  (inst_valid_o),
        .inst_ready_i  (inst_ready_i),
        .inst_o        (inst_o),
        .inst_addr_pc_o(inst_addr_pc_o),
        .fetch_err_o   (fetch_err_o),
        .jump_i        (jump_i),
        .jump_pc_i     (jump_pc_i),
        .flush_i       (flush_i),
        .flush_pc_i    (flush_pc_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    function automatic logic [63:0] mem_dw(input logic [63:0] addr);
        if (addr == 64'h8000_0000) return 64'h00100093_00000013;
        return {addr[31:0] ^ 32'hDEAD_0000, addr[31:0] + 32'h0000_1234};
    endfunction

    function automatic logic [31:0] mem_inst(input logic [63:0] pc);
        logic [63:0] dw;
        dw = mem_dw({pc[63:3], 3'b000});
        return pc[2] ? dw[63:32] : dw[31:0];
    endfunction

    task automatic wait_ar(input logic [63:0] exp_addr);
        for (int i = 0; i < 20 && !ar_valid_o; i++) @(negedge clk);
        if (!ar_valid_o) check("ar_timeout", 64'd0, 64'd1);
        else             check("ar_addr", ar_addr_o, exp_addr);
    endtask

    task automatic ar_hs();
        ar_ready_i = 1'b1;
        @(negedge clk);
        ar_ready_i = 1'b0;
        check("r_ready_in_r", {63'd0, r_ready_o}, 64'd1);
    endtask

    task automatic r_beat(input logic [63:0] addr, input logic [1:0] resp,
                          input bit drop, input logic [63:0] pc);
        exp_t e;
        r_valid_i = 1'b1;
        r_data_i  = mem_dw(addr);
        r_resp_i  = resp;
        if (!drop) begin
            e.inst = (resp != 2'b00) ? NOP : mem_inst(pc);
            e.pc   = pc;
            e.err  = (resp != 2'b00);
            sb.push_back(e);
        end
        @(negedge clk);
        r_valid_i = 1'b0;
        r_resp_i  = 2'b00;
        if (drop) check("beat_dropped", {63'd0, inst_valid_o}, 64'd0);
    endtask

    task automatic consume(input int hold, input bit jmp, input logic [63:0] jpc,
                           input bit fl, input logic [63:0] fpc, input bit rdy);
        exp_t e;
        for (int i = 0; i < 20 && !inst_valid_o; i++) @(negedge clk);
        if (!inst_valid_o) begin
            check("inst_timeout", 64'd0, 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check("inst", {32'd0, inst_o}, {32'd0, e.inst});
        check("inst_pc", inst_addr_pc_o, e.pc);
        check("fetch_err", {63'd0, fetch_err_o}, {63'd0, e.err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {63'd0, inst_valid_o}, 64'd1);
            check("hold_inst", {31'd0, fetch_err_o, inst_o}, {31'd0, e.err, e.inst});
            check("hold_pc", inst_addr_pc_o, e.pc);
        end
        inst_ready_i = rdy;
        jump_i       = jmp;
        jump_pc_i    = jpc;
        flush_i      = fl;
        flush_pc_i   = fpc;
        @(negedge clk);
        inst_ready_i = 1'b0;
        jump_i       = 1'b0;
        flush_i      = 1'b0;
        check("valid_drop", {63'd0, inst_valid_o}, 64'd0);
    endtask

    initial begin
        bit saw_ar;
        @(negedge clk);
        check("rst_ar_valid", {63'd0, ar_valid_o}, 64'd0);
        check("rst_r_ready", {63'd0, r_ready_o}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid_o}, 64'd0);
        check("rst_inst", {32'd0, inst_o}, 64'd0);
        check("rst_err", {63'd0, fetch_err_o}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_one_cycle", {63'd0, ar_valid_o}, 64'd1);

        // Two halves of the first doubleword, then a jump.
        wait_ar(64'h8000_0000);
        ar_hs();
        r_beat(64'h8000_0000, 2'b00, 1'b0, 64'h8000_0000);
        consume(0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        wait_ar(64'h8000_0000);
        ar_hs();
        r_beat(64'h8000_0000, 2'b00, 1'b0, 64'h8000_0004);
        consume(0, 1'b1, 64'h8000_0100, 1'b0, 64'd0, 1'b1);

        wait_ar(64'h8000_0100);
        ar_hs();
        r_beat(64'h8000_0100, 2'b00, 1'b0, 64'h8000_0100);
        consume(0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        // Flush while waiting in R: beat must be thrown away.
        wait_ar(64'h8000_0100);
        ar_hs();
        flush_i    = 1'b1;
        flush_pc_i = 64'h8000_0200;
        @(negedge clk);
        flush_i = 1'b0;
        check("r_wait_after_flush", {63'd0, r_ready_o}, 64'd1);
        r_beat(64'h8000_0100, 2'b00, 1'b1, 64'h8000_0104);

        // Error response, held output, then jump to a misaligned PC.
        wait_ar(64'h8000_0200);
        ar_hs();
        r_beat(64'h8000_0200, 2'b10, 1'b0, 64'h8000_0200);
        consume(5, 1'b1, 64'h8000_0102, 1'b0, 64'd0, 1'b1);

        begin
            exp_t e;
            e.inst = NOP;
            e.pc   = 64'h8000_0102;
            e.err  = 1'b1;
            sb.push_back(e);
        end
        saw_ar = 1'b0;
        for (int i = 0; i < 10 && !inst_valid_o; i++) begin
            if (ar_valid_o) saw_ar = 1'b1;
            @(negedge clk);
        end
        check("misaligned_no_ar", {63'd0, saw_ar}, 64'd0);
        consume(1, 1'b0, 64'd0, 1'b1, 64'h8000_0300, 1'b0);

        // Two flushes during AR: address held, latest target wins.
        wait_ar(64'h8000_0300);
        flush_i    = 1'b1;
        flush_pc_i = 64'h8000_0400;
        @(negedge clk);
        check("ar_stable_flush1", {63'd0, ar_valid_o}, 64'd1);
        check("ar_addr_flush1", ar_addr_o, 64'h8000_0300);
        flush_pc_i = 64'h8000_0500;
        @(negedge clk);
        flush_i = 1'b0;
        check("ar_addr_flush2", ar_addr_o, 64'h8000_0300);
        ar_hs();
        r_beat(64'h8000_0300, 2'b00, 1'b1, 64'h8000_0300);

        wait_ar(64'h8000_0500);
        ar_hs();
        r_beat(64'h8000_0500, 2'b00, 1'b0, 64'h8000_0500);
        consume(0, 1'b1, 64'h8000_0700, 1'b1, 64'h8000_0600, 1'b1);

        // Asynchronous reset in the middle of a read.
        wait_ar(64'h8000_0600);
        ar_hs();
        #2 rst = 1'b1;
        #1;
        check("async_rst_r_ready", {63'd0, r_ready_o}, 64'd0);
        check("async_rst_ar_valid", {63'd0, ar_valid_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ar(64'h8000_0000);
        ar_hs();
        r_beat(64'h8000_0000, 2'b00, 1'b0, 64'h8000_0000);
        consume(0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
